// File: rtl/fp_pkg.sv
// Shared single-precision constants and the normalizer state type.
// Imported by fp_pack and fp_normalize.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 25;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE
  } fpn_state_t;

endpackage

// File: rtl/fp_pack.sv
// Combinational packer: {sign, exp, frac} -> IEEE-754 single.
// force_inf wins over force_zero; both keep the sign.
// Ports:
//   sign        result sign
//   exp         biased exponent
//   frac        fraction bits (hidden bit excluded)
//   force_zero  emit signed zero
//   force_inf   emit signed infinity
//   packed_out  {sign, exp[7:0], frac[22:0]}
module fp_pack
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  input  logic              force_zero,
  input  logic              force_inf,
  output logic [31:0]       packed_out
);

  always_comb begin
    packed_out = {sign, exp, frac};
    if (force_inf) begin
      packed_out = {sign, EXP_MAX, {FRAC_W{1'b0}}};
    end else if (force_zero) begin
      packed_out = {sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    end
  end

endmodule

// File: rtl/fp_normalize.sv
// Post-add normalization stage. Absorbs the adder carry with a single
// right shift, strips leading zeros one bit per cycle, and hands the
// packed single out through a valid/ready handshake.
// Build option: define FP_NORMALIZE_FTZ_EN to flush subnormal results
// to signed zero.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (ready only in IDLE)
//   in_sign/exp/mant    raw sum; mant[24] carry, mant[23] hidden bit
//   out_valid/out_ready output handshake
//   out                 packed single result
//   out_ovf             result overflowed to infinity
module fp_normalize
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out,
  output logic              out_ovf
);

  fpn_state_t state, next_state;

  logic              sign_r;
  logic [EXP_W:0]    exp_r;   // one spare bit to see the 255 boundary
  logic [MANT_W-1:0] mant_r;
  logic              zero_r;
  logic              inf_r;
  logic              valid_r;
  logic [31:0]       out_r;
  logic              ovf_r;

  logic [EXP_W:0]    work_exp;
  logic [EXP_W:0]    inc_exp;
  logic [EXP_W:0]    dec_exp;
  logic [MANT_W-1:0] shl_mant;
  logic              is_special;
  logic              is_zero;
  logic              chk_done;
  logic              shift_ok;
  logic              force_zero;
  logic [31:0]       packed_res;

  always_comb begin
    work_exp   = (exp_r == '0) ? 9'd1 : exp_r;
    inc_exp    = work_exp + 9'd1;
    dec_exp    = exp_r - 9'd1;
    shl_mant   = {mant_r[MANT_W-2:0], 1'b0};
    is_special = (exp_r[EXP_W-1:0] == EXP_MAX);
    is_zero    = (mant_r == '0);
    chk_done   = is_special | is_zero | mant_r[24] | mant_r[23];
    shift_ok   = !mant_r[23] && (exp_r > 9'd1);
  end

`ifdef FP_NORMALIZE_FTZ_EN
  assign force_zero = zero_r | (exp_r == '0);
`else
  assign force_zero = zero_r;
`endif

  fp_pack u_pack (
    .sign       (sign_r),
    .exp        (exp_r[EXP_W-1:0]),
    .frac       (mant_r[FRAC_W-1:0]),
    .force_zero (force_zero),
    .force_inf  (inf_r),
    .packed_out (packed_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. SHIFT looks ahead at the shifted mantissa so the
  // last shift lands straight in DONE; DONE spends its first cycle
  // registering the packed result, which keeps latency at 2 + shifts.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (in_valid) next_state = CHECK;
      CHECK: next_state = chk_done ? DONE : SHIFT;
      SHIFT: if (!(shift_ok && !shl_mant[23])) next_state = DONE;
      DONE:  if (valid_r && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE) && rst_n;
    out_valid = valid_r;
    out       = out_r;
    out_ovf   = ovf_r;
  end

  // Working datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r  <= 1'b0;
      exp_r   <= '0;
      mant_r  <= '0;
      zero_r  <= 1'b0;
      inf_r   <= 1'b0;
      valid_r <= 1'b0;
      out_r   <= '0;
      ovf_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= {1'b0, in_exp};
            mant_r <= in_mant;
            zero_r <= 1'b0;
            inf_r  <= 1'b0;
          end
        end
        CHECK: begin
          if (is_special) begin
            // inf/NaN passes through untouched
          end else if (is_zero) begin
            zero_r <= 1'b1;
          end else if (mant_r[24]) begin
            mant_r <= mant_r >> 1;
            exp_r  <= inc_exp;
            if (inc_exp == {1'b0, EXP_MAX}) inf_r <= 1'b1;
          end else begin
            exp_r <= work_exp;
          end
        end
        SHIFT: begin
          if (shift_ok) begin
            mant_r <= shl_mant;
            exp_r  <= dec_exp;
          end else if (!mant_r[23]) begin
            exp_r <= '0;
          end
        end
        DONE: begin
          if (!valid_r) begin
            out_r   <= packed_res;
            ovf_r   <= inf_r;
            valid_r <= 1'b1;
          end else if (out_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
module tb_fp_normalize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  fp_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // Present one sum, wait for acceptance, then count cycles until
  // out_valid. lat = -1 when any bound expires.
  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m,
                      output int lat, output logic [31:0] res, output logic ovf);
    bit accepted = 0;
    lat = -1;
    res = 'x;
    ovf = 1'bx;
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin accepted = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (accepted) begin
      for (int n = 1; n <= 40; n++) begin
        if (n > 1) #1;
        if (n > 1 || 1) begin end
        @(posedge clk); #1;
        if (out_valid) begin lat = n; res = out; ovf = out_ovf; break; end
      end
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 00000000", out); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_normal();
    int lat; logic [31:0] r; logic o;
    send(1'b0, 8'h7F, 25'h0800000, lat, r, o);
    checks++; if (r !== 32'h3F800000) begin errors++; $display("FAIL one_out: got %h want 3f800000", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL one_lat: got %0d want 2", lat); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL one_ovf: got %b want 0", o); end
    take();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handoff_valid: got %b want 0", out_valid); end

    send(1'b0, 8'h7F, 25'h1800000, lat, r, o);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL carry_out: got %h want 40400000", r); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL carry_lat: got %0d want 2", lat); end
    take();

    send(1'b0, 8'h7F, 25'h0200000, lat, r, o);
    checks++; if (r !== 32'h3E800000) begin errors++; $display("FAIL shift2_out: got %h want 3e800000", r); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL shift2_lat: got %0d want 4", lat); end
    take();

    send(1'b0, 8'hFF, 25'h0400001, lat, r, o);
    checks++; if (r !== 32'h7FC00001) begin errors++; $display("FAIL nan_out: got %h want 7fc00001", r); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL nan_ovf: got %b want 0", o); end
    take();

    send(1'b1, 8'h00, 25'h0800000, lat, r, o);
    checks++; if (r !== 32'h80800000) begin errors++; $display("FAIL subin_norm_out: got %h want 80800000", r); end
    take();
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] r; logic o;
    send(1'b0, 8'hFE, 25'h1000000, lat, r, o);
    checks++; if (r !== 32'h7F800000) begin errors++; $display("FAIL ovf_out: got %h want 7f800000", r); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL ovf_lat: got %0d want 2", lat); end
    take();
  endtask

  task automatic test_subnormal();
    int lat; logic [31:0] r; logic o;
    logic [31:0] exp_a, exp_b;
`ifdef FP_NORMALIZE_FTZ_EN
    exp_a = 32'h00000000; exp_b = 32'h00000000;
`else
    exp_a = 32'h00200000; exp_b = 32'h00400000;
`endif
    send(1'b0, 8'h02, 25'h0100000, lat, r, o);
    checks++; if (r !== exp_a) begin errors++; $display("FAIL subn_out: got %h want %h", r, exp_a); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL subn_lat: got %0d want 4", lat); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL subn_ovf: got %b want 0", o); end
    take();

    send(1'b0, 8'h00, 25'h0400000, lat, r, o);
    checks++; if (r !== exp_b) begin errors++; $display("FAIL subn_pass_out: got %h want %h", r, exp_b); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL subn_pass_lat: got %0d want 3", lat); end
    take();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] r; logic o;
    send(1'b1, 8'h55, 25'h0000000, lat, r, o);
    checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL zero_out: got %h want 80000000", r); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out !== 32'h80000000) begin errors++; $display("FAIL hold_out[%0d]: got %h want 80000000", i, out); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    take();
  endtask

  task automatic test_reset_mid_shift();
    int lat; int seen; logic [31:0] r; logic o;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_stale: got %0d valid cycles want 0", seen); end

    // Worst-case normalization: 23 left shifts after the restart
    send(1'b0, 8'h7F, 25'h0000001, lat, r, o);
    checks++; if (r !== 32'h34000000) begin errors++; $display("FAIL shift23_out: got %h want 34000000", r); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL shift23_lat: got %0d want 25", lat); end
    take();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_overflow();
    test_subnormal();
    test_backpressure();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
